vga_text_renderer: RTL and testbench

VGA_TEXT_RENDERER -- requirements
Module: vga_text_renderer

---
 rtl/vga_text_pkg.sv | 43 ++++
 rtl/vga_timing.sv | 63 ++++++
 rtl/vga_text_renderer.sv | 107 ++++++++++
 tb/tb_vga_text_renderer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared raster timing, character-cell geometry and fetch-pipeline stage types.
package vga_text_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT       = 16;
    localparam int unsigned H_SYNC        = 96;
    localparam int unsigned H_BACK        = 48;
    localparam int unsigned H_TOTAL       = 800;

    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT       = 10;
    localparam int unsigned V_SYNC        = 2;
    localparam int unsigned V_BACK        = 33;
    localparam int unsigned V_TOTAL       = 525;

    localparam int unsigned CHAR_W        = 8;
    localparam int unsigned CHAR_H        = 16;
    localparam int unsigned COLS_DEF      = 80;
    localparam int unsigned ROWS_DEF      = 30;

    // Captured on the tick that issues the VRAM read.
    typedef struct packed {
        logic [3:0] row;
        logic [1:0] bsel;
        logic [2:0] px;
        logic       hs;
        logic       vs;
        logic       blank;
    } stage1_t;

    // Captured on the following tick, once the VRAM word is available.
    typedef struct packed {
        logic [2:0] px;
        logic       inv;
        logic       hs;
        logic       vs;
        logic       blank;
    } stage2_t;

    localparam stage1_t S1_RESET = '{row: '0, bsel: '0, px: '0, hs: 1'b1, vs: 1'b1, blank: 1'b0};
    localparam stage2_t S2_RESET = '{px: '0, inv: 1'b0, hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate timing: divide-by-two pixel clock, raster counters, raw sync and blank.
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_clk,
    output logic       tick,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hs,
    output logic       vs,
    output logic       blank
);

    localparam int unsigned H_END    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_END    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_STOP  = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_STOP  = VS_START + V_SYNC;

    logic run;

    // One idle CLK after reset so the first 0->1 of pixel_clk lands on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            pixel_clk <= 1'b0;
        end else begin
            run       <= 1'b1;
            pixel_clk <= run & ~pixel_clk;
        end
    end

    assign tick = run & ~pixel_clk;

    // Raster position; the tick carries the pre-advance (hc,vc).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (tick) begin
            if (hc == 10'(H_END - 1)) begin
                hc <= '0;
                vc <= (vc == 10'(V_END - 1)) ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

    // Raw sync pulses and visible-region flag decoded from the counters.
    always_comb begin
        hs    = !((hc >= 10'(HS_START)) && (hc < 10'(HS_STOP)));
        vs    = !((vc >= 10'(VS_START)) && (vc < 10'(VS_STOP)));
        blank = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
    end

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode VGA renderer: VRAM fetch, font lookup, colour mux and aligned sync outputs.
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic [9:0]  VRAM_ADDR,
    input  logic [31:0] VRAM_RDATA,
    output logic [10:0] FONT_ADDR,
    input  logic [7:0]  FONT_DATA,
    input  logic [11:0] FG_COLOR,
    input  logic [11:0] BG_COLOR,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic        pixel_clk
);

    logic        tick;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        hs_raw;
    logic        vs_raw;
    logic        vis;
    logic [11:0] idx;
    logic [7:0]  sel_byte;
    logic        pix_on;
    logic [11:0] colour;
    logic [11:0] fg_q;
    logic [11:0] bg_q;
    stage1_t     s1;
    stage2_t     s2;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE)
    ) u_timing (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .pixel_clk (pixel_clk),
        .tick      (tick),
        .hc        (hc),
        .vc        (vc),
        .hs        (hs_raw),
        .vs        (vs_raw),
        .blank     (vis)
    );

    assign sync = 1'b0;

    // Character index, byte select into the VRAM word, font address and pixel colour.
    always_comb begin
        idx       = 12'(vc[9:4]) * 12'(COLS) + 12'(hc[9:3]);
        sel_byte  = VRAM_RDATA[{s1.bsel, 3'b000} +: 8];
        FONT_ADDR = {sel_byte[6:0], s1.row};
        pix_on    = FONT_DATA[3'd7 - s2.px] ^ s2.inv;
        colour    = s2.blank ? (pix_on ? fg_q : bg_q) : '0;
    end

    // Tick-rate fetch pipeline; stage 2 samples the VRAM word one pixel after the address went out.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VRAM_ADDR <= '0;
            s1        <= S1_RESET;
            s2        <= S2_RESET;
            fg_q      <= '0;
            bg_q      <= '0;
        end else if (tick) begin
            VRAM_ADDR <= (vis && (idx < 12'(COLS * ROWS))) ? idx[11:2] : '0;
            s1        <= '{row: vc[3:0], bsel: idx[1:0], px: hc[2:0], hs: hs_raw, vs: vs_raw, blank: vis};
            s2        <= '{px: s1.px, inv: sel_byte[7], hs: s1.hs, vs: s1.vs, blank: s1.blank};
            if ((hc == '0) && (vc == '0)) begin
                fg_q <= FG_COLOR;
                bg_q <= BG_COLOR;
            end
        end
    end

    // Output register, loaded on the CLK edge between ticks once FONT_DATA is valid.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hs    <= 1'b1;
            vs    <= 1'b1;
            blank <= 1'b0;
        end else if (pixel_clk) begin
            red   <= colour[11:8];
            green <= colour[7:4];
            blue  <= colour[3:0];
            hs    <= s2.hs;
            vs    <= s2.vs;
            blank <= s2.blank;
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench for vga_text_renderer on a reduced raster (64x32 visible, 8x2 chars).
module tb_vga_text_renderer;

    localparam int HV     = 64;
    localparam int VV     = 32;
    localparam int NC     = 8;
    localparam int NR     = 2;
    localparam int HT     = HV + 16 + 96 + 48;
    localparam int VT     = VV + 10 + 2 + 33;
    localparam int NWORDS = NC * NR / 4;
    localparam int FRAME  = HT * VT;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [9:0]  VRAM_ADDR;
    logic [31:0] VRAM_RDATA;
    logic [10:0] FONT_ADDR;
    logic [7:0]  FONT_DATA;
    logic [11:0] FG_COLOR;
    logic [11:0] BG_COLOR;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        sync;
    logic        pixel_clk;

    logic [31:0] vram [0:NWORDS-1];
    logic [7:0]  font [0:2047];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          k        = 0;
    int          phase    = 0;
    logic [11:0] fg_drv, bg_drv, bg0, mfg, mbg;
    int          hs_fall, vs_fall, blank_cnt;
    logic        prev_hs, prev_vs, prev_blank;

    localparam logic [14:0] RESET_OUT = 15'b000000000000_110;

    vga_text_renderer #(
        .H_VISIBLE (HV),
        .V_VISIBLE (VV),
        .COLS      (NC),
        .ROWS      (NR)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .VRAM_ADDR  (VRAM_ADDR),
        .VRAM_RDATA (VRAM_RDATA),
        .FONT_ADDR  (FONT_ADDR),
        .FONT_DATA  (FONT_DATA),
        .FG_COLOR   (FG_COLOR),
        .BG_COLOR   (BG_COLOR),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .sync       (sync),
        .pixel_clk  (pixel_clk)
    );

    always #10 CLK = ~CLK;

    // Synchronous VRAM and font ROM: one CLK of read latency each.
    always @(posedge CLK) begin
        VRAM_RDATA <= (VRAM_ADDR < 10'(NWORDS)) ? vram[VRAM_ADDR[1:0]] : 32'hDEADBEEF;
        FONT_DATA  <= font[FONT_ADDR];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d phase %0d)", tag, got, exp, k, phase);
    endtask

    function automatic int px_hc(input int n);
        return n % HT;
    endfunction

    function automatic int px_vc(input int n);
        return (n / HT) % VT;
    endfunction

    function automatic logic px_vis(input int n);
        return (px_hc(n) < HV) && (px_vc(n) < VV);
    endfunction

    function automatic int char_idx(input int n);
        return (px_vc(n) / 16) * NC + px_hc(n) / 8;
    endfunction

    function automatic logic [7:0] char_byte(input int n);
        int          idx;
        logic [1:0]  wi;
        logic [31:0] w;
        idx = char_idx(n);
        wi  = 2'(idx / 4);
        w   = vram[wi];
        return 8'((w >> (8 * (idx % 4))) & 32'hFF);
    endfunction

    function automatic logic [10:0] exp_font_addr(input int n);
        logic [7:0] b;
        b = char_byte(n);
        return {b[6:0], 4'(px_vc(n) % 16)};
    endfunction

    function automatic logic [9:0] exp_addr(input int n);
        return px_vis(n) ? 10'(char_idx(n) / 4) : 10'd0;
    endfunction

    function automatic logic [14:0] exp_out(input int n, input logic [11:0] fg, input logic [11:0] bg);
        int          h, v;
        logic        vis, ehs, evs, on;
        logic [7:0]  b, fr;
        logic [11:0] rgb;
        h   = px_hc(n);
        v   = px_vc(n);
        vis = px_vis(n);
        ehs = !(h >= HV + 16 && h < HV + 112);
        evs = !(v >= VV + 10 && v < VV + 12);
        rgb = 12'h000;
        if (vis) begin
            b   = char_byte(n);
            fr  = font[exp_font_addr(n)];
            on  = ((fr >> (7 - h % 8)) & 8'h01) != 8'h00;
            on  = on ^ b[7];
            rgb = on ? fg : bg;
        end
        return {rgb, ehs, evs, vis};
    endfunction

    task automatic clear_trackers();
        hs_fall    = 0;
        vs_fall    = 0;
        blank_cnt  = 0;
        prev_hs    = 1'b1;
        prev_vs    = 1'b1;
        prev_blank = 1'b0;
    endtask

    task automatic run_edges(input int cnt);
        int          n;
        logic [14:0] out;
        for (int i = 0; i < cnt; i++) begin
            @(posedge CLK);
            k++;
            #1;
            check("pixel_clk", 32'(pixel_clk), 32'(k >= 2 && k % 2 == 0));
            if (k >= 2 && k % 2 == 0) begin
                n = (k - 2) / 2;
                if (px_hc(n) == 0 && px_vc(n) == 0) begin
                    mfg = fg_drv;
                    mbg = bg_drv;
                end
                check("vram_addr", 32'(VRAM_ADDR), 32'(exp_addr(n)));
                if (px_hc(n) == HV - 1 && px_vc(n) == VV - 1)
                    check("last_vram_addr", 32'(VRAM_ADDR), 32'(NWORDS - 1));
            end
            if (k >= 3 && k % 2 == 1) begin
                n = (k - 3) / 2;
                if (px_vis(n)) check("font_addr", 32'(FONT_ADDR), 32'(exp_font_addr(n)));
            end
            out = {red, green, blue, hs, vs, blank};
            if (k >= 5) begin
                n = (k - 5) / 2;
                check("pixel", 32'(out), 32'(exp_out(n, mfg, mbg)));
                if (k % 2 == 1 && phase == 0) begin
                    if (n == 0)     check("px00_fg", 32'(out[14:3]), 32'(12'hFFF));
                    if (n == 1)     check("px10_bg", 32'(out[14:3]), 32'(bg0));
                    if (n == 8)     check("inv_px8", 32'(out[14:3]), 32'(bg0));
                    if (n == 9)     check("inv_px9", 32'(out[14:3]), 32'(12'hFFF));
                    if (n == FRAME) check("frame2_red", 32'(out[14:3]), 32'(12'hF00));
                end
                if (k % 2 == 1 && phase == 1 && n == 0)
                    check("post_reset_red", 32'(out[14:3]), 32'(12'hF00));
            end else begin
                check("startup_out", 32'(out), 32'(RESET_OUT));
            end
            if (prev_hs && !hs) begin
                if (hs_fall > 0) check("hs_period", 32'(k - hs_fall), 32'(2 * HT));
                hs_fall = k;
            end
            if (!prev_hs && hs && hs_fall > 0) check("hs_low", 32'(k - hs_fall), 32'(2 * 96));
            if (prev_vs && !vs) begin
                if (vs_fall > 0) check("vs_period", 32'(k - vs_fall), 32'(2 * FRAME));
                vs_fall = k;
            end
            if (!prev_vs && vs && vs_fall > 0) check("vs_low", 32'(k - vs_fall), 32'(2 * 2 * HT));
            if (blank) blank_cnt++;
            if (prev_blank && !blank) check("blank_high", 32'(blank_cnt), 32'(2 * HV));
            if (!blank) blank_cnt = 0;
            prev_hs    = hs;
            prev_vs    = vs;
            prev_blank = blank;
        end
    endtask

    initial begin
        int target;
        for (int i = 0; i < NWORDS; i++) vram[i] = $urandom;
        vram[0] = 32'h0000C141;
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        font[11'h410] = 8'h80;
        fg_drv = 12'hFFF;
        bg_drv = 12'($urandom);
        if (bg_drv == 12'hFFF) bg_drv = 12'h0F0;
        bg0      = bg_drv;
        FG_COLOR = fg_drv;
        BG_COLOR = bg_drv;
        mfg      = '0;
        mbg      = '0;
        clear_trackers();

        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_out", 32'({red, green, blue, hs, vs, blank}), 32'(RESET_OUT));
        check("reset_pixel_clk", 32'(pixel_clk), 32'(0));
        check("reset_vram_addr", 32'(VRAM_ADDR), 32'(0));
        check("sync_tied", 32'(sync), 32'(0));

        @(negedge CLK);
        RESET_N = 1'b1;
        k = 0;
        run_edges(2 * (10 * HT + 30));

        fg_drv   = 12'hF00;
        FG_COLOR = fg_drv;
        bg_drv   = 12'($urandom);
        BG_COLOR = bg_drv;

        target = 2 * FRAME + 5 * HT + (HV + 60);
        run_edges(2 * target + 2 - k);

        #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset_out", 32'({red, green, blue, hs, vs, blank}), 32'(RESET_OUT));
        check("async_reset_pixel_clk", 32'(pixel_clk), 32'(0));
        check("async_reset_vram_addr", 32'(VRAM_ADDR), 32'(0));
        repeat (3) @(posedge CLK);
        #1;
        check("held_reset_out", 32'({red, green, blue, hs, vs, blank}), 32'(RESET_OUT));

        @(negedge CLK);
        RESET_N = 1'b1;
        k       = 0;
        phase   = 1;
        clear_trackers();
        run_edges(2 * HT * 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
